// File: rtl/key_debounce_if.sv
// Key debounce signal bundle: raw pins in, debounced level and change pulses out.
// PRESS/RELEASE exist only when KEY_DB_EDGE_EN is defined.
interface key_debounce_if #(
  parameter int KEY_BITS = 4
);
  logic [KEY_BITS-1:0] KEY_RAW;
  logic [KEY_BITS-1:0] KEY_STABLE;
  logic                CHANGED;
`ifdef KEY_DB_EDGE_EN
  logic [KEY_BITS-1:0] PRESS;
  logic [KEY_BITS-1:0] RELEASE;

  modport master (output KEY_RAW, input KEY_STABLE, input CHANGED, input PRESS, input RELEASE);
  modport slave  (input KEY_RAW, output KEY_STABLE, output CHANGED, output PRESS, output RELEASE);
`else
  modport master (output KEY_RAW, input KEY_STABLE, input CHANGED);
  modport slave  (input KEY_RAW, output KEY_STABLE, output CHANGED);
`endif
endinterface

// File: rtl/key_debounce.sv
// Per-key push-button debouncer: 2-flop sync, IDLE/COUNT FSM and counter per key.
// Define KEY_DB_EDGE_EN to add per-key PRESS/RELEASE pulses.
module key_debounce #(
  parameter int KEY_BITS  = 4,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_BITS  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  key_debounce_if.slave kif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DB_CYCLES - 1);

  logic [KEY_BITS-1:0] sync1, sync2;
  logic [KEY_BITS-1:0] stable_q;
  logic [KEY_BITS-1:0] accept;
  logic [0:0]          state_q [KEY_BITS];
  logic [0:0]          state_d [KEY_BITS];
  logic [CNT_BITS-1:0] cnt_q   [KEY_BITS];
  logic [CNT_BITS-1:0] cnt_d   [KEY_BITS];
  logic                changed_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= kif.KEY_RAW;
      sync2 <= sync1;
    end
  end

  // Each key only ever looks at its own sample, level, state and counter.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < KEY_BITS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (state_q[i] == IDLE) begin
        if (sync2[i] != stable_q[i]) begin
          state_d[i] = COUNT;
          cnt_d[i]   = CNT_BITS'(1);
        end else begin
          cnt_d[i]   = '0;
        end
      end else begin
        if (sync2[i] == stable_q[i]) begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          accept[i]  = 1'b1;
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i]   = cnt_q[i] + CNT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < KEY_BITS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      stable_q  <= '1;
      changed_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < KEY_BITS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      stable_q  <= stable_q ^ accept;
      changed_q <= |accept;
    end
  end

  assign kif.KEY_STABLE = stable_q;
  assign kif.CHANGED    = changed_q;

`ifdef KEY_DB_EDGE_EN
  logic [KEY_BITS-1:0] press_q, release_q;

  // Active-low keys: an accepted bit whose old level was 1 is a press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= accept & stable_q;
      release_q <= accept & ~stable_q;
    end
  end

  assign kif.PRESS   = press_q;
  assign kif.RELEASE = release_q;
`endif

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter KEY_BITS, default 4: number of physical push-button inputs.
REQ-002 Parameter DB_CYCLES, default 50000: consecutive stable samples required to accept a new level (1 ms at 50 MHz); legal range 2..2^CNT_BITS.
REQ-003 Parameter CNT_BITS, default 16: width of each per-key debounce counter.
REQ-004 CLK  input  1  system clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 KEY_RAW  input  KEY_BITS  raw active-low key pins, asynchronous to CLK, may bounce.
REQ-007 KEY_STABLE  output  KEY_BITS  debounced active-low key level, fed directly to the key device data input.
REQ-008 CHANGED  output  1  one-cycle pulse when any KEY_STABLE bit changes.
REQ-009 PRESS  output  KEY_BITS  one-cycle per-key press pulse (present only under KEY_DB_EDGE_EN).
REQ-010 RELEASE  output  KEY_BITS  one-cycle per-key release pulse (present only under KEY_DB_EDGE_EN).

Function
REQ-011 Each KEY_RAW bit SHALL pass through a two-flop synchronizer; the second-stage output is the sample S[i].
REQ-012 Each key SHALL have an independent two-state FSM, IDLE and COUNT, plus a CNT_BITS counter.
REQ-013 IDLE: S[i]==KEY_STABLE[i] -> remain, counter 0; S[i]!=KEY_STABLE[i] -> COUNT, counter 1.
REQ-014 COUNT: S[i]==KEY_STABLE[i] (bounce) -> IDLE, counter 0, KEY_STABLE[i] unchanged.
REQ-015 COUNT: S[i]!=KEY_STABLE[i] with counter==DB_CYCLES-1 -> KEY_STABLE[i]<=S[i], counter 0, IDLE; otherwise counter increments.
REQ-016 Latency: a clean KEY_RAW change between edges SHALL appear on KEY_STABLE at the (DB_CYCLES+2)th subsequent rising edge.
REQ-017 Any bounce shorter than DB_CYCLES consecutive samples SHALL produce no KEY_STABLE change and SHALL restart the count from zero.
REQ-018 CHANGED SHALL be registered and high for exactly the one cycle in which the new KEY_STABLE value first appears.
REQ-019 Multiple keys accepted on the same edge SHALL yield a single CHANGED pulse with all affected bits updated together.
REQ-020 Keys SHALL never interact: one key's bouncing SHALL not alter another key's counter or state.
REQ-021 Counter SHALL never wrap; it is bounded by DB_CYCLES-1 per REQ-015.

Reset
REQ-022 RST asserted SHALL immediately force synchronizer flops and KEY_STABLE to all ones (released), all FSMs to IDLE, counters to 0, CHANGED/PRESS/RELEASE to 0.
REQ-023 RST asserted mid-count SHALL discard the pending count; no pulse SHALL be generated on or after RST deassertion due to the abandoned count.
REQ-024 After RST deassertion, a key held pressed SHALL be accepted through the normal path, with latency per REQ-016 measured from the first edge after deassertion.

Configuration
REQ-025 Macro KEY_DB_EDGE_EN defined: PRESS[i] pulses one cycle when KEY_STABLE[i] goes 1->0, RELEASE[i] when 0->1, coincident with CHANGED.
REQ-026 Macro KEY_DB_EDGE_EN undefined: PRESS and RELEASE ports and their logic SHALL be absent; all other behaviour identical.

Verification (bench uses DB_CYCLES=4)
REQ-027 Clean press: KEY_RAW 4'hF->4'hE held -> KEY_STABLE=4'hE at 6th edge, CHANGED high exactly that one cycle.
REQ-028 Bounce: KEY_RAW[1] toggles every 3 cycles for 20 cycles, then holds 0 -> KEY_STABLE stays 4'hF during toggling, becomes 4'hD 6 edges after final transition.
REQ-029 Simultaneous: KEY_RAW 4'hF->4'h6 on one edge -> KEY_STABLE=4'h6 in one step, single CHANGED pulse.
REQ-030 Reset mid-count: KEY_RAW[3]=0, RST pulsed at 4th edge -> KEY_STABLE=4'hF, no CHANGED; with key still held, KEY_STABLE=4'h7 at 6th edge after RST release.
REQ-031 KEY_DB_EDGE_EN defined: press then release key 2 -> PRESS=4'h4 one cycle, later RELEASE=4'h4 one cycle, each coincident with CHANGED; undefined build compiles without those ports and passes REQ-027..030.
